// File: rtl/resource_lock_arbiter_pkg.sv
// Shared types and helpers for resource_lock_arbiter: per-port lock state,
// wrapping issue-ID age comparison and index-width helper.
package resource_lock_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    OWN  = 2'd2
  } port_state_e;

  localparam int AGE_W = 4;
  localparam logic [AGE_W-1:0] AGE_SAT = 4'd15;

  // Width needed to index n items, never less than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // a is older than b when (a - b) is negative in w-bit two's complement.
  function automatic logic id_older(input logic [63:0] a, input logic [63:0] b,
                                    input int w);
    return ((a - b) & (64'd1 << (w - 1))) != 64'd0;
  endfunction

endpackage

// File: rtl/resource_lock_arbiter_oldest_id_finder.sv
// Combinational reduction selecting the oldest candidate port by issue ID;
// ties resolve to the lower port index.
module oldest_id_finder
  import resource_lock_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 8,
  parameter int ID_WIDTH  = 16,
  parameter int PIDX_W    = 3
) (
  input  logic [NUM_PORTS-1:0]               cand,
  input  logic [NUM_PORTS-1:0][ID_WIDTH-1:0] ids,
  output logic                               found,
  output logic [PIDX_W-1:0]                  idx
);

  logic [ID_WIDTH-1:0] best;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    best  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (cand[p]) begin
        if (!found || id_older(64'(ids[p]), 64'(best), ID_WIDTH)) begin
          found = 1'b1;
          idx   = PIDX_W'(p);
          best  = ids[p];
        end
      end
    end
  end

endmodule

// File: rtl/resource_lock_arbiter.sv
// Lock-based arbiter sharing NUM_RES resources among NUM_PORTS requesters.
// Optional RLA_AGING_EN: starvation counters let a long-waiting port preempt age order.
module resource_lock_arbiter
  import resource_lock_arbiter_pkg::*;
#(
  parameter  int NUM_PORTS = 8,
  parameter  int NUM_RES   = 8,
  parameter  int ID_WIDTH  = 16,
  localparam int RES_W     = idx_w(NUM_RES),
  localparam int PIDX_W    = idx_w(NUM_PORTS)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_PORTS-1:0]               req_valid,
  input  logic [NUM_PORTS-1:0][ID_WIDTH-1:0] req_id,
  input  logic [NUM_PORTS-1:0]               res_release,
  input  logic                               flush,
  output logic [NUM_PORTS-1:0]               grant,
  output logic [NUM_PORTS-1:0][RES_W-1:0]    grant_res,
  output logic [NUM_RES-1:0]                 res_busy,
  output logic [NUM_RES-1:0][PIDX_W-1:0]     res_owner
);

  port_state_e state     [NUM_PORTS];
  port_state_e state_nxt [NUM_PORTS];

  logic [NUM_PORTS-1:0]            cand;
  logic [NUM_PORTS-1:0]            gnt_new;
  logic [NUM_PORTS-1:0][RES_W-1:0] res_new;
  logic [PIDX_W-1:0]               rr_ptr;
  logic [PIDX_W-1:0]               rr_nxt;
  logic                            old_found;
  logic [PIDX_W-1:0]               old_idx;
  logic                            sel_found;
  logic [PIDX_W-1:0]               sel_idx;
  logic [NUM_RES-1:0]              free_v;
  logic                            hit;
  int                              pp;
  logic [PIDX_W-1:0]               pidx;

  // An owning port's request is ignored, so a release+request waits one edge.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      cand[p]  = req_valid[p] && (state[p] != OWN);
      grant[p] = (state[p] == OWN);
    end
  end

  oldest_id_finder #(
    .NUM_PORTS (NUM_PORTS),
    .ID_WIDTH  (ID_WIDTH),
    .PIDX_W    (PIDX_W)
  ) u_oldest (
    .cand  (cand),
    .ids   (req_id),
    .found (old_found),
    .idx   (old_idx)
  );

`ifdef RLA_AGING_EN
  logic [NUM_PORTS-1:0][AGE_W-1:0] age;

  always_comb begin
    sel_found = old_found;
    sel_idx   = old_idx;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (cand[p] && (age[p] == AGE_SAT)) begin
        sel_found = 1'b1;
        sel_idx   = PIDX_W'(p);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (flush || gnt_new[p] || (state_nxt[p] != WAIT)) begin
          age[p] <= '0;
        end else if (age[p] != AGE_SAT) begin
          age[p] <= age[p] + 1'b1;
        end
      end
    end
  end
`else
  assign sel_found = old_found;
  assign sel_idx   = old_idx;
`endif

  // Pass 1 serves the selected (oldest) port, pass 2 scans from rr_ptr; both
  // draw the lowest free resource. Only resources free before this edge count.
  always_comb begin
    free_v  = ~res_busy;
    gnt_new = '0;
    res_new = '0;
    rr_nxt  = rr_ptr;
    hit     = 1'b0;
    pp      = 0;
    pidx    = '0;
    if (!flush) begin
      if (sel_found) begin
        for (int r = 0; r < NUM_RES; r++) begin
          if (!hit && free_v[r]) begin
            hit              = 1'b1;
            free_v[r]        = 1'b0;
            gnt_new[sel_idx] = 1'b1;
            res_new[sel_idx] = RES_W'(r);
          end
        end
      end
      for (int k = 0; k < NUM_PORTS; k++) begin
        pp = int'(rr_ptr) + k;
        if (pp >= NUM_PORTS) pp = pp - NUM_PORTS;
        pidx = PIDX_W'(pp);
        if (cand[pidx] && !gnt_new[pidx]) begin
          hit = 1'b0;
          for (int r = 0; r < NUM_RES; r++) begin
            if (!hit && free_v[r]) begin
              hit           = 1'b1;
              free_v[r]     = 1'b0;
              gnt_new[pidx] = 1'b1;
              res_new[pidx] = RES_W'(r);
              rr_nxt        = (pp == NUM_PORTS - 1) ? '0 : PIDX_W'(pp + 1);
            end
          end
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      state_nxt[p] = state[p];
      if (flush) begin
        state_nxt[p] = IDLE;
      end else begin
        case (state[p])
          OWN: if (res_release[p]) state_nxt[p] = IDLE;
          default: begin
            if (gnt_new[p])        state_nxt[p] = OWN;
            else if (req_valid[p]) state_nxt[p] = WAIT;
            else                   state_nxt[p] = IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PORTS; p++) state[p] <= IDLE;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) state[p] <= state_nxt[p];
    end
  end

  // Lock table: released and newly granted resources are always disjoint.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_res <= '0;
      res_busy  <= '0;
      res_owner <= '0;
      rr_ptr    <= '0;
    end else begin
      rr_ptr <= rr_nxt;
      if (flush) begin
        grant_res <= '0;
        res_busy  <= '0;
        res_owner <= '0;
      end else begin
        for (int p = 0; p < NUM_PORTS; p++) begin
          if ((state[p] == OWN) && res_release[p]) begin
            res_busy[grant_res[p]]  <= 1'b0;
            res_owner[grant_res[p]] <= '0;
            grant_res[p]            <= '0;
          end else if (gnt_new[p]) begin
            res_busy[res_new[p]]  <= 1'b1;
            res_owner[res_new[p]] <= PIDX_W'(p);
            grant_res[p]          <= res_new[p];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_resource_lock_arbiter.sv
// Directed plus randomized bench for resource_lock_arbiter (8 ports, 2 resources)
// against a behavioural lock-table model.
module tb_resource_lock_arbiter;

  localparam int NP = 8;
  localparam int NR = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NP-1:0]       req_valid;
  logic [NP-1:0][15:0] req_id;
  logic [NP-1:0]       res_release;
  logic                flush;
  logic [NP-1:0]       grant;
  logic [NP-1:0][0:0]  grant_res;
  logic [NR-1:0]       res_busy;
  logic [NR-1:0][2:0]  res_owner;

  int n_checks = 0;
  int n_fail   = 0;

  int own_res [NP];
  int owner   [NR];
  int age     [NP];
  int rr;
  logic [15:0] id_base;

  resource_lock_arbiter #(
    .NUM_PORTS (NP),
    .NUM_RES   (NR),
    .ID_WIDTH  (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_id      (req_id),
    .res_release (res_release),
    .flush       (flush),
    .grant       (grant),
    .grant_res   (grant_res),
    .res_busy    (res_busy),
    .res_owner   (res_owner)
  );

  always #5 clk = ~clk;

  function automatic bit older(input logic [15:0] a, input logic [15:0] b);
    logic signed [15:0] d;
    d = a - b;
    return d < 0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin own_res[p] = -1; age[p] = 0; end
    for (int r = 0; r < NR; r++) owner[r] = -1;
    rr = 0;
  endtask

  // Evaluates the arbitration rules on the inputs present before the next edge.
  task automatic model_step();
    bit cand [NP];
    bit gnt  [NP];
    int gres [NP];
    int freeq[$];
    int sel, last, p, cnt;
    if (flush) begin
      model_reset_locks();
      return;
    end
    for (int i = 0; i < NP; i++) begin
      cand[i] = req_valid[i] && (own_res[i] < 0);
      gnt[i]  = 1'b0;
      gres[i] = -1;
    end
    for (int r = 0; r < NR; r++) if (owner[r] < 0) freeq.push_back(r);
    sel = -1;
`ifdef RLA_AGING_EN
    for (int i = NP - 1; i >= 0; i--) if (cand[i] && age[i] >= 15) sel = i;
`endif
    if (sel < 0) begin
      for (int i = 0; i < NP; i++) begin
        if (cand[i]) begin
          cnt = 0;
          for (int j = 0; j < NP; j++)
            if (cand[j] && j != i &&
                (older(req_id[j], req_id[i]) || (req_id[j] == req_id[i] && j < i)))
              cnt++;
          if (cnt == 0 && sel < 0) sel = i;
        end
      end
    end
    if (sel >= 0 && freeq.size() > 0) begin
      gnt[sel] = 1'b1;
      gres[sel] = freeq.pop_front();
    end
    last = -1;
    for (int k = 0; k < NP; k++) begin
      p = (rr + k) % NP;
      if (cand[p] && !gnt[p] && freeq.size() > 0) begin
        gnt[p] = 1'b1;
        gres[p] = freeq.pop_front();
        last = p;
      end
    end
    if (last >= 0) rr = (last + 1) % NP;
    for (int i = 0; i < NP; i++) begin
      if (res_release[i] && own_res[i] >= 0) begin
        owner[own_res[i]] = -1;
        own_res[i] = -1;
      end
    end
    for (int i = 0; i < NP; i++) begin
      if (gnt[i]) begin own_res[i] = gres[i]; owner[gres[i]] = i; end
      age[i] = (cand[i] && !gnt[i]) ? ((age[i] < 15) ? age[i] + 1 : 15) : 0;
    end
  endtask

  task automatic model_reset_locks();
    for (int p = 0; p < NP; p++) begin own_res[p] = -1; age[p] = 0; end
    for (int r = 0; r < NR; r++) owner[r] = -1;
  endtask

  task automatic compare_all(input string tag);
    logic [NP-1:0]      e_grant;
    logic [NP-1:0][0:0] e_gres;
    logic [NR-1:0]      e_busy;
    logic [NR-1:0][2:0] e_owner;
    e_grant = '0; e_gres = '0; e_busy = '0; e_owner = '0;
    for (int p = 0; p < NP; p++) begin
      if (own_res[p] >= 0) begin e_grant[p] = 1'b1; e_gres[p] = 1'(own_res[p]); end
    end
    for (int r = 0; r < NR; r++) begin
      if (owner[r] >= 0) begin e_busy[r] = 1'b1; e_owner[r] = 3'(owner[r]); end
    end
    check({tag, ".grant"},     64'(grant),     64'(e_grant));
    check({tag, ".grant_res"}, 64'(grant_res), 64'(e_gres));
    check({tag, ".res_busy"},  64'(res_busy),  64'(e_busy));
    check({tag, ".res_owner"}, 64'(res_owner), 64'(e_owner));
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic idle_inputs();
    req_valid = '0; res_release = '0; flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req_id = '0;
    idle_inputs();
    model_reset();
    #12;
    check("reset.grant", 64'(grant), 64'd0);
    check("reset.grant_res", 64'(grant_res), 64'd0);
    check("reset.res_busy", 64'(res_busy), 64'd0);
    check("reset.res_owner", 64'(res_owner), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single request, all free
    req_valid[3] = 1'b1; req_id[3] = 16'd5;
    cycle("t1");
    check("t1.grant3", 64'(grant), 64'h08);
    check("t1.busy", 64'(res_busy), 64'b01);
    check("t1.owner0", 64'(res_owner[0]), 64'd3);
    idle_inputs(); res_release[3] = 1'b1;
    cycle("t1rel");
    idle_inputs();

    // oldest first, then round-robin
    req_valid[2:0] = 3'b111; req_id[0] = 16'd9; req_id[1] = 16'd4; req_id[2] = 16'd7;
    cycle("t2");
    check("t2.grant", 64'(grant), 64'h03);
    check("t2.gres1", 64'(grant_res[1]), 64'd0);
    check("t2.gres0", 64'(grant_res[0]), 64'd1);
    req_valid[1:0] = 2'b00;
    cycle("t2wait");
    check("t2wait.grant", 64'(grant), 64'h03);

    // release at edge N, re-grant after N+1
    res_release[1] = 1'b1;
    cycle("t3rel");
    check("t3rel.grant", 64'(grant), 64'h01);
    check("t3rel.busy", 64'(res_busy), 64'b10);
    res_release[1] = 1'b0;
    cycle("t3gnt");
    check("t3gnt.grant", 64'(grant), 64'h05);
    check("t3gnt.gres2", 64'(grant_res[2]), 64'd0);
    req_valid[2] = 1'b0; res_release[0] = 1'b1;
    cycle("t4free");
    res_release[0] = 1'b0;

    // ID wrap with one free resource
    req_valid[1:0] = 2'b11; req_id[0] = 16'h0001; req_id[1] = 16'hFFFE;
    cycle("t4");
    check("t4.grant", 64'(grant), 64'h06);
    check("t4.gres1", 64'(grant_res[1]), 64'd1);
    idle_inputs(); res_release[1] = 1'b1; res_release[2] = 1'b1;
    cycle("t4rel");
    idle_inputs();

    // flush beats simultaneous requests and releases
    req_valid[5:4] = 2'b11; req_id[4] = 16'd10; req_id[5] = 16'd11;
    cycle("t5own");
    req_valid[5:4] = 2'b00;
    req_valid[7:6] = 2'b11; req_id[6] = 16'd20; req_id[7] = 16'd21;
    cycle("t5wait");
    check("t5wait.grant", 64'(grant), 64'h30);
    flush = 1'b1; res_release[4] = 1'b1;
    cycle("t5flush");
    check("t5flush.grant", 64'(grant), 64'h00);
    check("t5flush.busy", 64'(res_busy), 64'b00);
    flush = 1'b0; res_release[4] = 1'b0;
    cycle("t5after");
    check("t5after.grant", 64'(grant), 64'hC0);

    // asynchronous reset mid-operation
    #2 rst_n = 1'b0;
    #1;
    check("arst.grant", 64'(grant), 64'd0);
    check("arst.res_busy", 64'(res_busy), 64'd0);
    check("arst.res_owner", 64'(res_owner), 64'd0);
    model_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic
    id_base = 16'hFF00;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < NP; p++) begin
        res_release[p] = 1'b0;
        if (own_res[p] >= 0) begin
          res_release[p] = ($urandom_range(0, 3) == 0);
          req_valid[p] = ($urandom_range(0, 3) == 0);
          if (req_valid[p]) req_id[p] = id_base + 16'($urandom_range(0, 200));
        end else if (req_valid[p]) begin
          if ($urandom_range(0, 19) == 0) req_valid[p] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req_valid[p] = 1'b1;
          req_id[p] = id_base + 16'($urandom_range(0, 200));
        end
      end
      flush = ($urandom_range(0, 39) == 0);
      id_base = id_base + 16'd3;
      cycle("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
